// File: rtl/scif_reg_pkg.sv
// Shared definitions for the SCIF register interface: register map,
// sticky-error bit positions and the packed SETUP register layout.
package scif_reg_pkg;

  localparam logic [4:0] REG_RX_SADDR   = 5'h00;
  localparam logic [4:0] REG_RX_SIZE    = 5'h01;
  localparam logic [4:0] REG_RX_CFG     = 5'h02;
  localparam logic [4:0] REG_TX_SADDR   = 5'h04;
  localparam logic [4:0] REG_TX_SIZE    = 5'h05;
  localparam logic [4:0] REG_TX_CFG     = 5'h06;
  localparam logic [4:0] REG_STATUS     = 5'h08;
  localparam logic [4:0] REG_SETUP      = 5'h09;
  localparam logic [4:0] REG_ERROR      = 5'h0A;
  localparam logic [4:0] REG_IRQ_EN     = 5'h0B;
  localparam logic [4:0] REG_RXQ_STATUS = 5'h0C;
  localparam logic [4:0] REG_RXQ_DATA   = 5'h0D;
  localparam logic [4:0] REG_ETU        = 5'h0E;
  localparam logic [4:0] REG_RXQ_CFG    = 5'h0F;
  localparam logic [4:0] REG_ERR_CNT    = 5'h10;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_PARITY   = 1;
  localparam int ERR_RXQ_OVF  = 2;
  localparam int ERR_W        = 3;

  localparam logic [7:0] WATERMARK_RST = 8'd1;

  typedef struct packed {
    logic [15:0] divider;
    logic [1:0]  clksel;
    logic        en_rx;
    logic        en_tx;
    logic        polling_en;
    logic        stop_bits;
    logic [1:0]  num_bits;
    logic        parity_en;
  } setup_t;

  // Extract SETUP fields from a bus word.
  function automatic setup_t setup_from_word(input logic [31:0] d);
    setup_t s;
    s.divider    = d[31:16];
    s.clksel     = d[15:14];
    s.en_rx      = d[9];
    s.en_tx      = d[8];
    s.polling_en = d[4];
    s.stop_bits  = d[3];
    s.num_bits   = d[2:1];
    s.parity_en  = d[0];
    return s;
  endfunction

  // Place SETUP fields back at their bus positions for readback.
  function automatic logic [31:0] setup_to_word(input setup_t s);
    logic [31:0] d;
    d        = '0;
    d[31:16] = s.divider;
    d[15:14] = s.clksel;
    d[9]     = s.en_rx;
    d[8]     = s.en_tx;
    d[4]     = s.polling_en;
    d[3]     = s.stop_bits;
    d[2:1]   = s.num_bits;
    d[0]     = s.parity_en;
    return d;
  endfunction

endpackage

// File: rtl/udma_scif_rxq.sv
// Synchronous RX character queue with flush, level and full/empty flags.
// Push into a full queue and pop from an empty one are ignored; flush wins
// over any same-cycle push or pop.
module udma_scif_rxq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [DATA_W-1:0]            data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (level == LVL_W'(DEPTH));
  assign empty_o = (level == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];
  assign level_o = level;

  // Pointer and level bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/udma_scif_reg_rxq_if.sv
// Register interface for the uDMA SCIF peripheral: uDMA channel config,
// line setup, RX queue with watermark IRQ, sticky errors and counters.
import scif_reg_pkg::*;

module udma_scif_reg_rxq_if #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int DATA_W         = 8,
  parameter int RXQ_DEPTH      = 8,
  parameter int CNT_W          = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic [31:0]               cfg_data_i,
  input  logic [4:0]                cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,

  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,

  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic                      cfg_tx_continuous_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic                      cfg_tx_en_i,
  input  logic                      cfg_tx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,

  input  logic [1:0]                status_i,
  input  logic                      err_parity_i,
  input  logic                      err_overflow_i,

  input  logic [DATA_W-1:0]         rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,

  output logic [15:0]               divider_o,
  output logic [15:0]               etu_o,
  output logic [1:0]                clksel_o,
  output logic [1:0]                num_bits_o,
  output logic                      stop_bits_o,
  output logic                      parity_en_o,
  output logic                      en_rx_o,
  output logic                      en_tx_o,
  output logic                      rx_polling_en_o,
  output logic                      rx_irq_o,
  output logic                      err_irq_o
);

  localparam int LVL_W = $clog2(RXQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              wr_en;
  logic              rd_en;
  setup_t            setup_q;
  logic [15:0]       etu_q;
  logic [1:0]        irq_en_q;
  logic [7:0]        watermark_q;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_set;
  logic [ERR_W-1:0]  err_clr;
  logic [CNT_W-1:0]  par_cnt_q;
  logic [CNT_W-1:0]  ovf_cnt_q;

  logic              rxq_push;
  logic              rxq_pop;
  logic              rxq_flush;
  logic [DATA_W-1:0] rxq_data;
  logic [LVL_W-1:0]  rxq_level;
  logic              rxq_full;
  logic              rxq_empty;
  logic [31:0]       level_ext;
  logic [7:0]        wm_eff;

  assign wr_en       = cfg_valid_i & ~cfg_rwn_i;
  assign rd_en       = cfg_valid_i &  cfg_rwn_i;
  assign cfg_ready_o = 1'b1;

  // RX uDMA channel configuration; en/clr are one-cycle pulses after the write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rx_startaddr_o  <= '0;
      cfg_rx_size_o       <= '0;
      cfg_rx_continuous_o <= 1'b0;
      cfg_rx_en_o         <= 1'b0;
      cfg_rx_clr_o        <= 1'b0;
    end else begin
      cfg_rx_en_o  <= 1'b0;
      cfg_rx_clr_o <= 1'b0;
      if (wr_en && cfg_addr_i == REG_RX_SADDR) cfg_rx_startaddr_o <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
      if (wr_en && cfg_addr_i == REG_RX_SIZE)  cfg_rx_size_o      <= cfg_data_i[TRANS_SIZE-1:0];
      if (wr_en && cfg_addr_i == REG_RX_CFG) begin
        cfg_rx_continuous_o <= cfg_data_i[0];
        cfg_rx_en_o         <= cfg_data_i[4];
        cfg_rx_clr_o        <= cfg_data_i[6];
      end
    end
  end

  // TX uDMA channel configuration, same layout as RX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_tx_startaddr_o  <= '0;
      cfg_tx_size_o       <= '0;
      cfg_tx_continuous_o <= 1'b0;
      cfg_tx_en_o         <= 1'b0;
      cfg_tx_clr_o        <= 1'b0;
    end else begin
      cfg_tx_en_o  <= 1'b0;
      cfg_tx_clr_o <= 1'b0;
      if (wr_en && cfg_addr_i == REG_TX_SADDR) cfg_tx_startaddr_o <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
      if (wr_en && cfg_addr_i == REG_TX_SIZE)  cfg_tx_size_o      <= cfg_data_i[TRANS_SIZE-1:0];
      if (wr_en && cfg_addr_i == REG_TX_CFG) begin
        cfg_tx_continuous_o <= cfg_data_i[0];
        cfg_tx_en_o         <= cfg_data_i[4];
        cfg_tx_clr_o        <= cfg_data_i[6];
      end
    end
  end

  // Line setup, ETU, IRQ enables and RX queue watermark.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      setup_q     <= '0;
      etu_q       <= '0;
      irq_en_q    <= '0;
      watermark_q <= WATERMARK_RST;
    end else if (wr_en) begin
      case (cfg_addr_i)
        REG_SETUP:   setup_q     <= setup_from_word(cfg_data_i);
        REG_ETU:     etu_q       <= cfg_data_i[15:0];
        REG_IRQ_EN:  irq_en_q    <= cfg_data_i[1:0];
        REG_RXQ_CFG: watermark_q <= cfg_data_i[7:0];
        default:     ;
      endcase
    end
  end

  assign divider_o       = setup_q.divider;
  assign clksel_o        = setup_q.clksel;
  assign num_bits_o      = setup_q.num_bits;
  assign stop_bits_o     = setup_q.stop_bits;
  assign parity_en_o     = setup_q.parity_en;
  assign en_rx_o         = setup_q.en_rx;
  assign en_tx_o         = setup_q.en_tx;
  assign rx_polling_en_o = setup_q.polling_en;
  assign etu_o           = etu_q;

  // Queue control. Turning polling off through SETUP also discards queued data.
  assign rx_ready_o = setup_q.polling_en & ~rxq_full;
  assign rxq_push   = rx_valid_i & rx_ready_o;
  assign rxq_pop    = rd_en & (cfg_addr_i == REG_RXQ_DATA) & ~rxq_empty;
  assign rxq_flush  = wr_en & (((cfg_addr_i == REG_RXQ_CFG) & cfg_data_i[31]) |
                               ((cfg_addr_i == REG_SETUP)   & ~cfg_data_i[4]));

  udma_scif_rxq #(
    .DATA_W (DATA_W),
    .DEPTH  (RXQ_DEPTH)
  ) u_rxq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rxq_push),
    .data_i  (rx_data_i),
    .pop_i   (rxq_pop),
    .flush_i (rxq_flush),
    .data_o  (rxq_data),
    .level_o (rxq_level),
    .full_o  (rxq_full),
    .empty_o (rxq_empty)
  );

  assign err_set[ERR_OVERFLOW] = err_overflow_i;
  assign err_set[ERR_PARITY]   = err_parity_i;
  assign err_set[ERR_RXQ_OVF]  = rx_valid_i & setup_q.polling_en & rxq_full;
  assign err_clr = (wr_en && cfg_addr_i == REG_ERROR) ? cfg_data_i[ERR_W-1:0] : '0;

  // Sticky errors: a new error pulse wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= (err_q & ~err_clr) | err_set;
  end

  // Saturating error counters; any write to ERR_CNT clears both and wins over an increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else if (wr_en && cfg_addr_i == REG_ERR_CNT) begin
      par_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      if (err_parity_i   && par_cnt_q != CNT_MAX) par_cnt_q <= par_cnt_q + CNT_W'(1);
      if (err_overflow_i && ovf_cnt_q != CNT_MAX) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
    end
  end

  // A watermark of zero behaves as one, so an empty queue never raises the IRQ.
  assign level_ext = 32'(rxq_level);
  assign wm_eff    = (watermark_q == 8'd0) ? 8'd1 : watermark_q;

  // Registered interrupt outputs, one cycle behind their conditions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_irq_o  <= 1'b0;
      err_irq_o <= 1'b0;
    end else begin
      rx_irq_o  <= irq_en_q[0] & (level_ext >= {24'd0, wm_eff});
      err_irq_o <= irq_en_q[1] & (|err_q);
    end
  end

  // Read mux; SADDR/SIZE reads show the live channel pointer and remaining bytes.
  always_comb begin
    cfg_data_o = '0;
    if (rd_en) begin
      case (cfg_addr_i)
        REG_RX_SADDR:   cfg_data_o = 32'(cfg_rx_curr_addr_i);
        REG_RX_SIZE:    cfg_data_o = 32'(cfg_rx_bytes_left_i);
        REG_RX_CFG:     cfg_data_o = {26'd0, cfg_rx_pending_i, cfg_rx_en_i, 3'b000, cfg_rx_continuous_o};
        REG_TX_SADDR:   cfg_data_o = 32'(cfg_tx_curr_addr_i);
        REG_TX_SIZE:    cfg_data_o = 32'(cfg_tx_bytes_left_i);
        REG_TX_CFG:     cfg_data_o = {26'd0, cfg_tx_pending_i, cfg_tx_en_i, 3'b000, cfg_tx_continuous_o};
        REG_STATUS:     cfg_data_o = {30'd0, status_i};
        REG_SETUP:      cfg_data_o = setup_to_word(setup_q);
        REG_ERROR:      cfg_data_o = 32'(err_q);
        REG_IRQ_EN:     cfg_data_o = {30'd0, irq_en_q};
        REG_RXQ_STATUS: cfg_data_o = {16'd0, level_ext[7:0], 6'd0, rxq_full, rxq_empty};
        REG_RXQ_DATA: begin
          if (!rxq_empty) begin
            cfg_data_o     = 32'(rxq_data);
            cfg_data_o[31] = 1'b1;
          end
        end
        REG_ETU:        cfg_data_o = {16'd0, etu_q};
        REG_RXQ_CFG:    cfg_data_o = {24'd0, watermark_q};
        REG_ERR_CNT:    cfg_data_o = (32'(par_cnt_q) << 8) | 32'(ovf_cnt_q);
        default:        cfg_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_scif_reg_rxq_if.sv
// Directed bench for udma_scif_reg_rxq_if with hand-computed expectations.
module tb_udma_scif_reg_rxq_if;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] cfg_data_i = '0;
  logic [4:0]  cfg_addr_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_rwn_i = 1'b0;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;
  logic [11:0] cfg_rx_startaddr_o, cfg_tx_startaddr_o;
  logic [15:0] cfg_rx_size_o, cfg_tx_size_o;
  logic        cfg_rx_continuous_o, cfg_rx_en_o, cfg_rx_clr_o;
  logic        cfg_tx_continuous_o, cfg_tx_en_o, cfg_tx_clr_o;
  logic        cfg_rx_en_i = 1'b0, cfg_rx_pending_i = 1'b0;
  logic        cfg_tx_en_i = 1'b0, cfg_tx_pending_i = 1'b0;
  logic [11:0] cfg_rx_curr_addr_i = '0, cfg_tx_curr_addr_i = '0;
  logic [15:0] cfg_rx_bytes_left_i = '0, cfg_tx_bytes_left_i = '0;
  logic [1:0]  status_i = '0;
  logic        err_parity_i = 1'b0, err_overflow_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [15:0] divider_o, etu_o;
  logic [1:0]  clksel_o, num_bits_o;
  logic        stop_bits_o, parity_en_o, en_rx_o, en_tx_o, rx_polling_en_o;
  logic        rx_irq_o, err_irq_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd;

  udma_scif_reg_rxq_if dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
    .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
    .cfg_rx_startaddr_o(cfg_rx_startaddr_o), .cfg_rx_size_o(cfg_rx_size_o),
    .cfg_rx_continuous_o(cfg_rx_continuous_o), .cfg_rx_en_o(cfg_rx_en_o),
    .cfg_rx_clr_o(cfg_rx_clr_o), .cfg_rx_en_i(cfg_rx_en_i),
    .cfg_rx_pending_i(cfg_rx_pending_i), .cfg_rx_curr_addr_i(cfg_rx_curr_addr_i),
    .cfg_rx_bytes_left_i(cfg_rx_bytes_left_i),
    .cfg_tx_startaddr_o(cfg_tx_startaddr_o), .cfg_tx_size_o(cfg_tx_size_o),
    .cfg_tx_continuous_o(cfg_tx_continuous_o), .cfg_tx_en_o(cfg_tx_en_o),
    .cfg_tx_clr_o(cfg_tx_clr_o), .cfg_tx_en_i(cfg_tx_en_i),
    .cfg_tx_pending_i(cfg_tx_pending_i), .cfg_tx_curr_addr_i(cfg_tx_curr_addr_i),
    .cfg_tx_bytes_left_i(cfg_tx_bytes_left_i),
    .status_i(status_i), .err_parity_i(err_parity_i), .err_overflow_i(err_overflow_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .divider_o(divider_o), .etu_o(etu_o), .clksel_o(clksel_o), .num_bits_o(num_bits_o),
    .stop_bits_o(stop_bits_o), .parity_en_o(parity_en_o), .en_rx_o(en_rx_o),
    .en_tx_o(en_tx_o), .rx_polling_en_o(rx_polling_en_o),
    .rx_irq_o(rx_irq_o), .err_irq_o(err_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All drive tasks start and end 1 ns after a rising edge.
  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_addr_i = a; cfg_data_i = d; cfg_rwn_i = 1'b0; cfg_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
    cfg_addr_i = a; cfg_rwn_i = 1'b1; cfg_valid_i = 1'b1;
    #2 d = cfg_data_o;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] ch);
    rx_data_i = ch; rx_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    idle(1);

    // Reset state
    check("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    check("rst_irqs", {30'd0, rx_irq_o, err_irq_o}, 32'd0);
    check("rst_divider", 32'(divider_o), 32'd0);
    cfg_rd(5'h0F, rd); check("rst_watermark", rd, 32'h1);
    cfg_rd(5'h0C, rd); check("rst_rxq_status", rd, 32'h1);
    cfg_rd(5'h03, rd); check("unmapped_rd", rd, 32'h0);

    // SETUP programming
    cfg_wr(5'h09, 32'h0010_0312);
    check("setup_div", 32'(divider_o), 32'h10);
    check("setup_en_rx_tx", {30'd0, en_rx_o, en_tx_o}, 32'h3);
    check("setup_polling", 32'(rx_polling_en_o), 32'h1);
    check("setup_bits_par", {29'd0, num_bits_o, parity_en_o}, 32'h2);
    check("setup_rx_ready", 32'(rx_ready_o), 32'h1);
    cfg_rd(5'h09, rd); check("setup_readback", rd, 32'h0010_0312);

    // Basic queue ordering and empty read
    push(8'h41); push(8'h42); push(8'h43);
    cfg_rd(5'h0C, rd); check("q3_level", rd, 32'h0000_0300);
    cfg_rd(5'h0D, rd); check("q3_pop0", rd, 32'h8000_0041);
    cfg_rd(5'h0D, rd); check("q3_pop1", rd, 32'h8000_0042);
    cfg_rd(5'h0D, rd); check("q3_pop2", rd, 32'h8000_0043);
    cfg_rd(5'h0D, rd); check("q3_pop_empty", rd, 32'h0);
    cfg_rd(5'h0C, rd); check("q3_after_empty", rd, 32'h1);
    cfg_rd(5'h0A, rd); check("q3_no_error", rd, 32'h0);

    // Fill to depth and overflow
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    check("full_rx_ready", 32'(rx_ready_o), 32'h0);
    push(8'h58);
    cfg_rd(5'h0A, rd); check("ovf_error", rd, 32'h4);
    cfg_rd(5'h0C, rd); check("full_status", rd, 32'h0000_0802);
    cfg_rd(5'h0D, rd); check("full_first", rd, 32'h8000_0050);
    cfg_wr(5'h0A, 32'h4);
    cfg_rd(5'h0A, rd); check("ovf_w1c", rd, 32'h0);
    cfg_wr(5'h0F, 32'h8000_0001);
    cfg_rd(5'h0C, rd); check("flush_status", rd, 32'h1);
    cfg_rd(5'h0F, rd); check("flush_reads0", rd, 32'h1);

    // Watermark IRQ
    cfg_wr(5'h0F, 32'h4);
    cfg_wr(5'h0B, 32'h1);
    push(8'h61); push(8'h62); push(8'h63);
    idle(1);
    check("wm_3_irq", 32'(rx_irq_o), 32'h0);
    push(8'h64);
    check("wm_4_latency", 32'(rx_irq_o), 32'h0);
    idle(1);
    check("wm_4_irq", 32'(rx_irq_o), 32'h1);
    cfg_rd(5'h0D, rd); check("wm_pop", rd, 32'h8000_0061);
    check("wm_pop_still", 32'(rx_irq_o), 32'h1);
    idle(1);
    check("wm_pop_deassert", 32'(rx_irq_o), 32'h0);

    // Flush beats a same-cycle push at level 5
    push(8'h65); push(8'h66);
    cfg_rd(5'h0C, rd); check("pre_flush_level", rd, 32'h0000_0500);
    rx_data_i = 8'h67; rx_valid_i = 1'b1;
    cfg_wr(5'h0F, 32'h8000_0004);
    rx_valid_i = 1'b0;
    cfg_rd(5'h0C, rd); check("flush_vs_push", rd, 32'h1);

    // Parity counter saturation and set-beats-clear
    for (int i = 0; i < 300; i++) begin
      err_parity_i = 1'b1; @(posedge clk_i); #1;
      err_parity_i = 1'b0; @(posedge clk_i); #1;
    end
    cfg_rd(5'h10, rd); check("par_cnt_sat", rd, 32'h0000_FF00);
    err_parity_i = 1'b1;
    cfg_wr(5'h0A, 32'h2);
    err_parity_i = 1'b0;
    cfg_rd(5'h0A, rd); check("set_beats_w1c", rd, 32'h2);
    cfg_wr(5'h0B, 32'h3);
    idle(1);
    check("err_irq", 32'(err_irq_o), 32'h1);
    cfg_wr(5'h0A, 32'h2);
    cfg_rd(5'h0A, rd); check("par_w1c", rd, 32'h0);
    for (int i = 0; i < 3; i++) begin
      err_overflow_i = 1'b1; @(posedge clk_i); #1;
      err_overflow_i = 1'b0; @(posedge clk_i); #1;
    end
    cfg_rd(5'h10, rd); check("ovf_cnt", rd, 32'h0000_FF03);
    err_parity_i = 1'b1;
    cfg_wr(5'h10, 32'h0);
    err_parity_i = 1'b0;
    cfg_rd(5'h10, rd); check("cnt_clr_wins", rd, 32'h0);

    // Channel config pulses
    cfg_rx_pending_i = 1'b1;
    cfg_wr(5'h02, 32'h51);
    check("rx_cfg_pulse", {29'd0, cfg_rx_en_o, cfg_rx_clr_o, cfg_rx_continuous_o}, 32'h7);
    idle(1);
    check("rx_cfg_pulse_end", {29'd0, cfg_rx_en_o, cfg_rx_clr_o, cfg_rx_continuous_o}, 32'h1);
    cfg_rd(5'h02, rd); check("rx_cfg_rd", rd, 32'h21);
    cfg_wr(5'h05, 32'h0000_1234);
    check("tx_size", 32'(cfg_tx_size_o), 32'h1234);

    // Asynchronous reset mid-operation
    push(8'h70); push(8'h71);
    cfg_wr(5'h0B, 32'h1);
    cfg_wr(5'h0F, 32'h1);
    idle(1);
    check("pre_rst_irq", 32'(rx_irq_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_outs", {26'd0, rx_irq_o, err_irq_o, rx_ready_o, en_rx_o, en_tx_o,
                              cfg_rx_continuous_o}, 32'h0);
    check("rst_async_div", 32'(divider_o), 32'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    cfg_rd(5'h0F, rd); check("post_rst_wm", rd, 32'h1);
    cfg_rd(5'h0C, rd); check("post_rst_q", rd, 32'h1);
    cfg_rd(5'h10, rd); check("post_rst_cnt", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/udma_scif_reg_rxq_if.md
Name: udma_scif_reg_rxq_if

Overview:
- Next-generation register interface for the uDMA SCIF (smart-card/UART) peripheral.
- Keeps the uDMA RX/TX channel configuration registers.
- Replaces the single-byte polled RX holding register with a parametrised RX queue that has a watermark interrupt.
- Adds write-1-to-clear sticky errors, saturating error counters and registered IRQ outputs.
- Sits between the APB/uDMA cfg bus and the SCIF core.

Parameters:
- L2_AWIDTH_NOAL, 12, uDMA L2 address width.
- TRANS_SIZE, 16, uDMA transfer-size width.
- DATA_W, 8, RX character width (8 or 9).
- RXQ_DEPTH, 8, RX queue entries; power of two, ≥2.
- CNT_W, 8, error-counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high. One clock, no other clock domains.
- cfg_data_i  in  32  write data.
- cfg_addr_i  in  5  word address.
- cfg_valid_i  in  1  access strobe.
- cfg_rwn_i  in  1  1 = read, 0 = write.
- cfg_data_o  out  32  read data (combinational).
- cfg_ready_o  out  1  tied 1.
- cfg_rx_startaddr_o/size_o/continuous_o/en_o/clr_o  out  L2_AWIDTH_NOAL/TRANS_SIZE/1/1/1  RX channel config.
- cfg_rx_en_i/pending_i/curr_addr_i/bytes_left_i  in  1/1/L2_AWIDTH_NOAL/TRANS_SIZE  RX channel status.
- cfg_tx_* (same widths, directions and meanings as cfg_rx_*)  TX channel.
- status_i  in  2  core busy flags.
- err_parity_i, err_overflow_i  in  1  core error pulses.
- rx_data_i  in  DATA_W  received character.
- rx_valid_i  in  1  character valid.
- rx_ready_o  out  1  queue accepts.
- divider_o  out  16  baud divider.
- etu_o  out  16  ETU value.
- clksel_o  out  2  clock select.
- num_bits_o  out  2  character length.
- stop_bits_o, parity_en_o, en_rx_o, en_tx_o, rx_polling_en_o  out  1  line configuration.
- rx_irq_o, err_irq_o  out  1  interrupts (registered).

Behaviour:
- Register map (word address):
  - 0x00 RX_SADDR; 0x01 RX_SIZE; 0x02 RX_CFG (wr: bit6 clr, bit4 en, bit0 cont; rd: {pending, en, 000, cont} at bits 5..0).
  - 0x04..0x06 TX equivalents.
  - 0x08 STATUS (ro {30'0, status_i}).
  - 0x09 SETUP: [31:16] div, [15:14] clksel, [9] en_rx, [8] en_tx, [4] polling_en, [3] stop, [2:1] bits, [0] parity.
  - 0x0A ERROR: bit0 core overflow, bit1 parity, bit2 queue overflow; W1C. Reads are non-destructive.
  - 0x0B IRQ_EN: bit1 err, bit0 rx.
  - 0x0C RXQ_STATUS (ro): [15:8] level, bit1 full, bit0 empty.
  - 0x0D RXQ_DATA: {valid, DATA_W data}, valid at bit31; the read pops the queue.
  - 0x0E ETU [15:0].
  - 0x0F RXQ_CFG: [7:0] watermark; bit31 flush (write-only pulse, reads 0).
  - 0x10 ERR_CNT: [15:8] parity count, [7:0] overflow count. Any write clears both.
  - Unmapped: reads 0, writes ignored.
- Reset values: all registers and outputs 0, except watermark = 1. rx_ready_o = 0.
- rx_clr/tx_clr/rx_en/tx_en outputs are 1-cycle pulses, generated the cycle after the write.
- Queue push: rx_valid_i & rx_ready_o, where rx_ready_o = polling_en & ~full (registered state only).
- rx_valid_i while polling_en & full: no push; ERROR bit2 set; data dropped.
- Queue pop: cfg read of 0x0D while not empty. Data is valid in the same cycle. Level decrements next edge.
- Read of 0x0D while empty: returns 0, no pop, no error.
- Simultaneous push and pop (not empty, not full): level unchanged, order preserved.
- Push while empty with a same-cycle read: the read returns empty; the new entry lands.
- Flush: RXQ_CFG bit31 write, or a SETUP write with polling_en = 0. Empties the queue at the next edge. Flush beats a same-cycle push.
- Level width is clog2(RXQ_DEPTH+1). Pointers wrap modulo RXQ_DEPTH.
- Sticky errors: a set pulse has priority over a same-cycle W1C.
- Counters increment on each err_* pulse and saturate at 2^CNT_W−1. A clear-write beats a same-cycle increment.
- IRQs, updated each edge:
  - rx_irq_o <= rx_irq_en & (level >= max(watermark, 1)).
  - err_irq_o <= err_irq_en & |ERROR.
  - Latency: 1 cycle after the condition.
- Asserting rst_i mid-operation immediately clears the queue, errors, counters and IRQs.

Decomposition:
- Package scif_reg_pkg:
  - register address localparams;
  - ERROR bit indices;
  - a typedef struct for the SETUP fields.
- Sub-module udma_scif_rxq: synchronous FIFO (push/pop/flush, level, full/empty). Instantiated once.

Test Plan:
- Write SETUP 0x0010_0312 -> divider_o = 0x0010, en_rx_o = 1, en_tx_o = 1, polling_en = 1, num_bits_o = 1, parity_en_o = 0. Readback is equal.
- Polling on; push 0x41, 0x42, 0x43 -> RXQ_STATUS level = 3. Three reads of 0x0D return 0x8000_0041, 0x8000_0042, 0x8000_0043. Fourth read returns 0, level stays 0.
- Depth 8: push 9 characters -> rx_ready_o = 0 after the 8th; ERROR = 0x4; first read returns the 1st character. Write ERROR 0x4 -> ERROR reads 0.
- Watermark 4, rx_irq_en = 1: 3 pushes -> rx_irq_o = 0. 4th push -> rx_irq_o = 1 one cycle later. One pop -> deasserts the cycle after the level update.
- err_parity_i pulsed 300 times -> ERR_CNT[15:8] = 0xFF. The W1C for ERROR bit1 is written in the same cycle as a pulse -> bit1 stays 1.
- Flush write concurrent with a push at level 5 -> level 0 next cycle. Assert rst_i mid-transfer -> all outputs 0 and watermark reads 1.
